// File: rtl/pmp_core.sv
// Multi-unit byte-stream pattern matcher: each unit holds a 1..8 byte pattern,
// streams command bytes through an 8-byte history and raises a sticky match flag.
module pmp_core #(
  parameter int unsigned NO_MODULES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [0:NO_MODULES-1][63:0]    data,
  input  logic [0:NO_MODULES-1][15:0]    control,
  input  logic [31:0]                    data_ready,
  output logic [31:0]                    data_accepted,
  output logic [31:0]                    pattern_accepted
);

  localparam int unsigned BYTES = 8;
  localparam int unsigned CW    = 4;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STREAM = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic {ST_IDLE, ST_STREAM} state_e;

  logic [NO_MODULES-1:0] acc_w;
  logic [NO_MODULES-1:0] match_w;

  logic unused_ready;
  assign unused_ready = ^data_ready[31:NO_MODULES];

  for (genvar i = 0; i < NO_MODULES; i++) begin : g_unit
    state_e        state_q;
    logic [63:0]   pattern_q;
    logic [63:0]   hist_q;
    logic [63:0]   sdata_q;
    logic [CW-1:0] plen_q;
    logic [CW-1:0] hcount_q;
    logic [CW-1:0] rem_q;
    logic          done_q;
    logic          stag_q;
    logic          match_q;

    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic          tag;
    logic          cmd_new;
    logic [63:0]   hist_d;
    logic [CW-1:0] hcount_d;
    logic [2:0]    pidx;
    logic          hit;
    logic          unused_ctrl;

    assign unused_ctrl = ^control[i][9:0];

    // Decode command and evaluate the match on the history after this byte's shift.
    always_comb begin
      op       = control[i][15:14];
      cnt      = {1'b0, control[i][13:11]} + 4'd1;
      tag      = control[i][10];
      cmd_new  = (state_q == ST_IDLE) && data_ready[i] && (op != OP_NOP) && (tag != done_q);
      hist_d   = {hist_q[55:0], sdata_q[7:0]};
      hcount_d = (hcount_q == 4'(BYTES)) ? 4'(BYTES) : hcount_q + 4'd1;
      hit      = (hcount_d >= plen_q);
      pidx     = '0;
      // Newest byte (history slot 0) lines up with pattern byte plen-1.
      for (int j = 0; j < int'(BYTES); j++) begin
        pidx = 3'(plen_q - 4'd1 - 4'(j));
        if ((4'(j) < plen_q) && (hist_d[8*j +: 8] != pattern_q[{pidx, 3'b000} +: 8])) begin
          hit = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        pattern_q <= '0;
        hist_q    <= '0;
        sdata_q   <= '0;
        plen_q    <= 4'd1;
        hcount_q  <= '0;
        rem_q     <= '0;
        done_q    <= 1'b0;
        stag_q    <= 1'b0;
        match_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_new) begin
              case (op)
                OP_LOAD: begin
                  pattern_q <= data[i];
                  plen_q    <= cnt;
                  hist_q    <= '0;
                  hcount_q  <= '0;
                  match_q   <= 1'b0;
                  done_q    <= tag;
                end
                OP_CLEAR: begin
                  hcount_q <= '0;
                  match_q  <= 1'b0;
                  done_q   <= tag;
                end
                OP_STREAM: begin
                  sdata_q <= data[i];
                  rem_q   <= cnt;
                  stag_q  <= tag;
                  state_q <= ST_STREAM;
                end
                default: ;
              endcase
            end
          end
          ST_STREAM: begin
            hist_q   <= hist_d;
            hcount_q <= hcount_d;
            sdata_q  <= sdata_q >> 8;
            rem_q    <= rem_q - 4'd1;
            if (hit) begin
              match_q <= 1'b1;
            end
            if (rem_q == 4'd1) begin
              done_q  <= stag_q;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign acc_w[i]   = (state_q == ST_IDLE) && data_ready[i] && (done_q == tag);
    assign match_w[i] = match_q;
  end

  assign data_accepted    = 32'(acc_w);
  assign pattern_accepted = 32'(match_w);

endmodule

// File: tb/tb_pmp_core.sv
// Directed bench for pmp_core with a queue-based behavioural model checked every cycle.
module tb_pmp_core;

  localparam int NU = 4;

  logic              clk;
  logic              reset;
  logic [0:NU-1][63:0] data;
  logic [0:NU-1][15:0] control;
  logic [31:0]       data_ready;
  logic [31:0]       data_accepted;
  logic [31:0]       pattern_accepted;

  int n_cmp;
  int n_bad;

  pmp_core #(.NO_MODULES(NU)) dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .control          (control),
    .data_ready       (data_ready),
    .data_accepted    (data_accepted),
    .pattern_accepted (pattern_accepted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pattern as byte list, history as a bounded queue of arrived bytes.
  byte unsigned m_pat  [NU][8];
  int           m_plen [NU];
  byte unsigned m_hist [NU][$];
  byte unsigned m_rem  [NU][$];
  bit           m_done [NU];
  bit           m_match[NU];
  bit           m_busy [NU];
  bit           m_stag [NU];
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int u = 0; u < NU; u++) begin
        for (int k = 0; k < 8; k++) m_pat[u][k] = 8'h00;
        m_plen[u] = 1;
        m_hist[u].delete();
        m_rem[u].delete();
        m_done[u] = 1'b0; m_match[u] = 1'b0; m_busy[u] = 1'b0; m_stag[u] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int u = 0; u < NU; u++) begin
        int op, cnt, sz;
        bit tg, ok;
        byte unsigned b;
        op  = int'(control[u][15:14]);
        cnt = int'(control[u][13:11]) + 1;
        tg  = control[u][10];
        if (m_busy[u]) begin
          b = m_rem[u].pop_front();
          m_hist[u].push_back(b);
          if (m_hist[u].size() > 8) void'(m_hist[u].pop_front());
          sz = m_hist[u].size();
          if (sz >= m_plen[u]) begin
            ok = 1'b1;
            for (int k = 0; k < m_plen[u]; k++)
              if (m_hist[u][sz - m_plen[u] + k] != m_pat[u][k]) ok = 1'b0;
            if (ok) m_match[u] = 1'b1;
          end
          if (m_rem[u].size() == 0) begin
            m_busy[u] = 1'b0;
            m_done[u] = m_stag[u];
          end
        end else if (data_ready[u] && op != 0 && tg != m_done[u]) begin
          case (op)
            1: begin
              for (int k = 0; k < 8; k++) m_pat[u][k] = data[u][8*k +: 8];
              m_plen[u] = cnt;
              m_hist[u].delete();
              m_match[u] = 1'b0;
              m_done[u] = tg;
            end
            2: begin
              m_rem[u].delete();
              for (int k = 0; k < cnt; k++) m_rem[u].push_back(data[u][8*k +: 8]);
              m_stag[u] = tg;
              m_busy[u] = 1'b1;
            end
            default: begin
              m_hist[u].delete();
              m_match[u] = 1'b0;
              m_done[u] = tg;
            end
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] e_acc, e_pat;
      e_acc = '0;
      e_pat = '0;
      for (int u = 0; u < NU; u++) begin
        e_acc[u] = !m_busy[u] && data_ready[u] && (m_done[u] == control[u][10]);
        e_pat[u] = m_match[u];
      end
      n_cmp++;
      if (data_accepted !== e_acc) begin
        n_bad++;
        $display("FAIL model_acc t=%0t got=%h exp=%h", $time, data_accepted, e_acc);
      end
      n_cmp++;
      if (pattern_accepted !== e_pat) begin
        n_bad++;
        $display("FAIL model_pat t=%0t got=%h exp=%h", $time, pattern_accepted, e_pat);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int u, input logic [1:0] op, input logic [2:0] cm1,
                         input logic tg, input logic [63:0] d);
    control[u]    = {op, cm1, tg, 10'h000};
    data[u]       = d;
    data_ready[u] = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    data = '0;
    control = '0;
    data_ready = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("reset_acc", data_accepted, 32'h0);
    check("reset_pat", pattern_accepted, 32'h0);

    // LOAD "AB"
    set_cmd(0, 2'b01, 3'd1, 1'b1, 64'h4241);
    tick(1);
    check("load_acc", data_accepted, 32'h1);
    check("load_pat", pattern_accepted, 32'h0);

    // STREAM "ABCD": busy for 4 cycles, accepted at the 5th
    set_cmd(0, 2'b10, 3'd3, 1'b0, 64'h44434241);
    tick(1);
    check("strm_busy_acc", data_accepted, 32'h0);
    tick(3);
    check("strm_last_acc", data_accepted, 32'h0);
    tick(1);
    check("strm_done_acc", data_accepted, 32'h1);
    check("strm_done_pat", pattern_accepted, 32'h1);

    // CLEAR, then a repeated tag must be ignored
    set_cmd(0, 2'b11, 3'd0, 1'b1, 64'h0);
    tick(1);
    check("clear_pat", pattern_accepted, 32'h0);
    check("clear_acc", data_accepted, 32'h1);
    set_cmd(0, 2'b10, 3'd1, 1'b1, 64'h4241);
    tick(3);
    check("stale_tag_pat", pattern_accepted, 32'h0);
    check("stale_tag_acc", data_accepted, 32'h1);

    // Split pattern "xA" | "By"; inputs disturbed mid-stream
    set_cmd(0, 2'b10, 3'd1, 1'b0, 64'h4178);
    tick(1);
    data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    data_ready[0] = 1'b0;
    tick(2);
    check("split1_pat", pattern_accepted, 32'h0);
    set_cmd(0, 2'b10, 3'd1, 1'b0, 64'hDEAD);
    #1;
    check("split1_acc", data_accepted, 32'h1);
    set_cmd(0, 2'b10, 3'd1, 1'b1, 64'h7942);
    tick(3);
    check("split2_pat", pattern_accepted, 32'h1);
    check("split2_acc", data_accepted, 32'h1);

    // Broadcast 8-byte LOAD, then match streamed only into unit 2
    set_cmd(0, 2'b01, 3'd7, 1'b0, 64'h1122_3344_5566_7788);
    for (int u = 1; u < NU; u++) set_cmd(u, 2'b01, 3'd7, 1'b1, 64'h1122_3344_5566_7788);
    tick(1);
    check("bcast_acc", data_accepted, 32'hF);
    check("bcast_pat", pattern_accepted, 32'h0);
    data_ready = '0;
    set_cmd(2, 2'b10, 3'd7, 1'b0, 64'h1122_3344_5566_7788);
    tick(8);
    check("u2_pre_pat", pattern_accepted, 32'h0);
    check("u2_pre_acc", data_accepted, 32'h0);
    tick(1);
    check("u2_pat", pattern_accepted, 32'h4);
    check("u2_acc", data_accepted, 32'h4);

    // Reset mid-stream on unit 1
    data_ready = '0;
    set_cmd(1, 2'b10, 3'd7, 1'b0, 64'h1122_3344_5566_7788);
    tick(3);
    reset = 1'b1;
    data_ready = '0;
    tick(1);
    reset = 1'b0;
    check("rst_mid_acc", data_accepted, 32'h0);
    check("rst_mid_pat", pattern_accepted, 32'h0);
    set_cmd(1, 2'b01, 3'd0, 1'b1, 64'h55);
    tick(1);
    check("post_rst_load", data_accepted, 32'h2);
    set_cmd(1, 2'b10, 3'd0, 1'b0, 64'h55);
    tick(1);
    check("post_rst_busy", data_accepted, 32'h0);
    tick(1);
    check("post_rst_pat", pattern_accepted, 32'h2);
    check("post_rst_acc", data_accepted, 32'h2);

    // All units streaming in parallel, checked by the model
    for (int u = 0; u < NU; u++) set_cmd(u, 2'b10, 3'(u + 2), (u == 1) ? 1'b1 : 1'b0, 64'h0123_4567_89AB_CDEF);
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
